// File: rtl/osd_diagnosis_config_writer_pkg.sv
// rtl/osd_diagnosis_config_writer_pkg.sv - DII flit type, register-access codes and writer FSM states
package osd_diagnosis_config_writer_pkg;

  // One DII ring flit: handshake valid, end-of-packet marker, payload.
  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;

  localparam logic [1:0] TYPE_REG               = 2'b00;
  localparam logic [3:0] REQ_WRITE_REG_16       = 4'b0100;
  localparam logic [3:0] RESP_WRITE_REG_SUCCESS = 4'b1110;
  localparam logic [3:0] RESP_WRITE_REG_ERROR   = 4'b1111;

  // Bit positions inside the flags flit of a DII packet.
  localparam int FLAGS_TYPE_MSB    = 15;
  localparam int FLAGS_TYPE_LSB    = 14;
  localparam int FLAGS_SUBTYPE_MSB = 13;
  localparam int FLAGS_SUBTYPE_LSB = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_SEND,
    ST_WAIT_RESP,
    ST_NEXT,
    ST_DONE
  } fsm_state_t;

  // Build a flags flit from type and subtype; remaining bits are zero.
  function automatic logic [15:0] make_flags(input logic [1:0] ftype, input logic [3:0] subtype);
    logic [15:0] f;
    f = '0;
    f[FLAGS_TYPE_MSB:FLAGS_TYPE_LSB]       = ftype;
    f[FLAGS_SUBTYPE_MSB:FLAGS_SUBTYPE_LSB] = subtype;
    return f;
  endfunction

endpackage

// File: rtl/osd_diagnosis_config_writer_resp_parser.sv
// rtl/osd_diagnosis_config_writer_resp_parser.sv - frames incoming DII flits and flags write responses addressed to us
module osd_dii_resp_parser
  import osd_diagnosis_config_writer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] id,
  input  logic [15:0] target_id,
  input  dii_flit     debug_in,
  output logic        resp_valid,
  output logic        resp_ok,
  output logic        resp_err
);

  // pos_q: 0 dest, 1 src, 2 flags, 3 skipping the tail of an over-long packet.
  logic [1:0] pos_q, pos_d;
  logic       match_q, match_d;
  logic       hdr_ok;
  logic [1:0] ftype;
  logic [3:0] fsub;

  // Track flit position and header match; a response is only recognised on a 3-flit packet.
  always_comb begin
    pos_d   = pos_q;
    match_d = match_q;
    ftype   = debug_in.data[FLAGS_TYPE_MSB:FLAGS_TYPE_LSB];
    fsub    = debug_in.data[FLAGS_SUBTYPE_MSB:FLAGS_SUBTYPE_LSB];
    hdr_ok  = debug_in.valid && debug_in.last && (pos_q == 2'd2) && match_q && (ftype == TYPE_REG);
    resp_ok    = hdr_ok && (fsub == RESP_WRITE_REG_SUCCESS);
    resp_err   = hdr_ok && (fsub == RESP_WRITE_REG_ERROR);
    resp_valid = resp_ok || resp_err;
    if (debug_in.valid) begin
      if (debug_in.last) begin
        pos_d   = 2'd0;
        match_d = 1'b0;
      end else begin
        case (pos_q)
          2'd0: begin
            match_d = (debug_in.data == id);
            pos_d   = 2'd1;
          end
          2'd1: begin
            match_d = match_q && (debug_in.data == target_id);
            pos_d   = 2'd2;
          end
          default: begin
            match_d = 1'b0;
            pos_d   = 2'd3;
          end
        endcase
      end
    end
  end

  // Parser position register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q   <= 2'd0;
      match_q <= 1'b0;
    end else begin
      pos_q   <= pos_d;
      match_q <= match_d;
    end
  end

endmodule

// File: rtl/osd_diagnosis_config_writer.sv
// rtl/osd_diagnosis_config_writer.sv - streams config words to a diagnosis module as DII register writes
module osd_diagnosis_config_writer
  import osd_diagnosis_config_writer_pkg::*;
#(
  parameter int MAX_WORDS    = 64,
  parameter int RESP_TIMEOUT = 1024,
  parameter int ABORT_ON_ERR = 1,
  localparam int AW          = $clog2(MAX_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   id,
  input  logic [15:0]   target_id,
  input  logic          start,
  input  logic [15:0]   cfg_base,
  input  logic [AW:0]   cfg_count,
  output logic [AW-1:0] cfg_rd_addr,
  output logic          cfg_rd_en,
  input  logic [15:0]   cfg_rd_data,
  output dii_flit       debug_out,
  input  logic          debug_out_ready,
  input  dii_flit       debug_in,
  output logic          debug_in_ready,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [7:0]    err_count
);

  localparam int            TW       = $clog2(RESP_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(RESP_TIMEOUT - 1);

  fsm_state_t    state_q, state_d;
  logic [AW:0]   idx_q, idx_d, count_q, count_d, idx_inc;
  logic [15:0]   base_q, base_d, tgt_q, tgt_d, data_q, data_d;
  logic [2:0]    flit_q, flit_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic [7:0]    errcnt_q, errcnt_d;
  logic          fail;
  logic          resp_valid, resp_ok, resp_err;

  osd_dii_resp_parser u_parser (
    .clk        (clk),
    .rst        (rst),
    .id         (id),
    .target_id  (tgt_q),
    .debug_in   (debug_in),
    .resp_valid (resp_valid),
    .resp_ok    (resp_ok),
    .resp_err   (resp_err)
  );

  assign idx_inc        = idx_q + 1'b1;
  assign cfg_rd_addr    = idx_q[AW-1:0];
  assign debug_in_ready = 1'b1;
  assign busy           = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done           = (state_q == ST_DONE);
  assign err            = err_q;
  assign err_count      = errcnt_q;

  // Sequencer: fetch a word, send it as a 5-flit write, wait for the reply, advance.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    count_d   = count_q;
    base_d    = base_q;
    tgt_d     = tgt_q;
    data_d    = data_q;
    flit_d    = flit_q;
    tmo_d     = tmo_q;
    err_d     = err_q;
    errcnt_d  = errcnt_q;
    fail      = 1'b0;
    cfg_rd_en = 1'b0;
    debug_out = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d   = cfg_base;
          count_d  = cfg_count;
          tgt_d    = target_id;
          err_d    = 1'b0;
          errcnt_d = 8'd0;
          idx_d    = '0;
          state_d  = (cfg_count == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        cfg_rd_en = 1'b1;
        state_d   = ST_LATCH;
      end
      ST_LATCH: begin
        data_d  = cfg_rd_data;
        flit_d  = 3'd0;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        debug_out.valid = 1'b1;
        debug_out.last  = (flit_q == 3'd4);
        case (flit_q)
          3'd0:    debug_out.data = tgt_q;
          3'd1:    debug_out.data = id;
          3'd2:    debug_out.data = make_flags(TYPE_REG, REQ_WRITE_REG_16);
          3'd3:    debug_out.data = base_q + 16'(idx_q);
          default: debug_out.data = data_q;
        endcase
        if (debug_out_ready) begin
          if (flit_q == 3'd4) begin
            flit_d  = 3'd0;
            tmo_d   = '0;
            state_d = ST_WAIT_RESP;
          end else begin
            flit_d = flit_q + 3'd1;
          end
        end
      end
      ST_WAIT_RESP: begin
        // A response landing on the timeout cycle is checked first, so it wins.
        if (resp_valid && resp_ok) begin
          state_d = ST_NEXT;
        end else if (resp_valid && resp_err) begin
          fail = 1'b1;
        end else if (tmo_q == TMO_LAST) begin
          fail = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
        if (fail) begin
          err_d = 1'b1;
          if (errcnt_q != 8'hFF) begin
            errcnt_d = errcnt_q + 8'd1;
          end
          state_d = (ABORT_ON_ERR != 0) ? ST_DONE : ST_NEXT;
        end
      end
      ST_NEXT: begin
        idx_d   = idx_inc;
        state_d = (idx_inc == count_q) ? ST_DONE : ST_FETCH;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      count_q  <= '0;
      base_q   <= 16'h0;
      tgt_q    <= 16'h0;
      data_q   <= 16'h0;
      flit_q   <= 3'd0;
      tmo_q    <= '0;
      err_q    <= 1'b0;
      errcnt_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      count_q  <= count_d;
      base_q   <= base_d;
      tgt_q    <= tgt_d;
      data_q   <= data_d;
      flit_q   <= flit_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
      errcnt_q <= errcnt_d;
    end
  end

endmodule

// File: tb/tb_osd_diagnosis_config_writer.sv
// tb/tb_osd_diagnosis_config_writer.sv - scoreboard bench for the DII config writer
module tb_osd_diagnosis_config_writer;
  import osd_diagnosis_config_writer_pkg::*;

  localparam logic [15:0] ID     = 16'h0001;
  localparam logic [15:0] TGT    = 16'h00AB;
  localparam logic [15:0] FL_REQ = 16'h1000;
  localparam logic [15:0] FL_OK  = 16'h3800;
  localparam logic [15:0] FL_ERR = 16'h3C00;
  localparam int PL_OK = 0, PL_ERR = 1, PL_NONE = 2, PL_FOREIGN = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [15:0] cfg_base_r = 16'h0;
  logic [3:0]  cfg_cnt_r = 4'd0;
  logic [15:0] rd_data = 16'h0;
  logic        dready = 1'b1;
  dii_flit     din;
  logic [15:0] mem [0:7];

  dii_flit     dout_a, dout_b, dout;
  logic [2:0]  rd_addr_a, rd_addr_b, rd_addr_s;
  logic        rd_en_a, rd_en_b, rd_en_s;
  logic        dinr_a, dinr_b, dinr_s;
  logic        busy_a, busy_b, busy_s, done_a, done_b, done_s, err_a, err_b, err_s;
  logic [7:0]  errc_a, errc_b, errc_s;
  logic        sel = 1'b0;

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  int ready_mode = 0;
  int resp_pending = 0;
  int resp_plan;
  int first_valid_cyc = -1, start_cyc = 0, last_f4_cyc = -1, mon_pos = 0;
  logic        prev_stall = 1'b0;
  logic [16:0] prev_flit = '0;
  logic [16:0] exp_q [$];
  int          plan_q [$];
  int          gaps [$];

  osd_diagnosis_config_writer #(.MAX_WORDS(8), .RESP_TIMEOUT(16), .ABORT_ON_ERR(1)) dut_a (
    .clk(clk), .rst(rst), .id(ID), .target_id(TGT), .start(start_a),
    .cfg_base(cfg_base_r), .cfg_count(cfg_cnt_r), .cfg_rd_addr(rd_addr_a), .cfg_rd_en(rd_en_a),
    .cfg_rd_data(rd_data), .debug_out(dout_a), .debug_out_ready(dready), .debug_in(din),
    .debug_in_ready(dinr_a), .busy(busy_a), .done(done_a), .err(err_a), .err_count(errc_a));

  osd_diagnosis_config_writer #(.MAX_WORDS(8), .RESP_TIMEOUT(16), .ABORT_ON_ERR(0)) dut_b (
    .clk(clk), .rst(rst), .id(ID), .target_id(TGT), .start(start_b),
    .cfg_base(cfg_base_r), .cfg_count(cfg_cnt_r), .cfg_rd_addr(rd_addr_b), .cfg_rd_en(rd_en_b),
    .cfg_rd_data(rd_data), .debug_out(dout_b), .debug_out_ready(dready), .debug_in(din),
    .debug_in_ready(dinr_b), .busy(busy_b), .done(done_b), .err(err_b), .err_count(errc_b));

  assign dout      = sel ? dout_b : dout_a;
  assign rd_addr_s = sel ? rd_addr_b : rd_addr_a;
  assign rd_en_s   = sel ? rd_en_b : rd_en_a;
  assign dinr_s    = sel ? dinr_b : dinr_a;
  assign busy_s    = sel ? busy_b : busy_a;
  assign done_s    = sel ? done_b : done_a;
  assign err_s     = sel ? err_b : err_a;
  assign errc_s    = sel ? errc_b : errc_a;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rd_en_s) rd_data <= mem[rd_addr_s];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_word(input logic [15:0] base, input int idx, input logic [15:0] d);
    logic [15:0] a;
    a = base + 16'(idx);
    exp_q.push_back({1'b0, TGT});
    exp_q.push_back({1'b0, ID});
    exp_q.push_back({1'b0, FL_REQ});
    exp_q.push_back({1'b0, a});
    exp_q.push_back({1'b1, d});
  endtask

  task automatic send_flit(input logic l, input logic [15:0] d);
    din.valid = 1'b1;
    din.last  = l;
    din.data  = d;
    @(negedge clk);
    din.valid = 1'b0;
    din.last  = 1'b0;
  endtask

  task automatic send_pkt(input logic [15:0] dst, input logic [15:0] src, input logic [15:0] fl);
    send_flit(1'b0, dst);
    send_flit(1'b0, src);
    send_flit(1'b1, fl);
  endtask

  // Ring readiness changes just after the rising edge so it is stable at the monitor's sample.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       dready = 1'b1;
        1:       dready = 1'($urandom_range(0, 1));
        default: dready = 1'b0;
      endcase
    end
  end

  // Responder: answers each completed request according to the plan queue.
  initial begin
    din = '0;
    forever begin
      @(negedge clk);
      if (resp_pending > 0) begin
        resp_pending--;
        if (plan_q.size() > 0) begin
          resp_plan = plan_q.pop_front();
          repeat (3) @(negedge clk);
          if (resp_plan == PL_FOREIGN) begin
            send_pkt(16'h0055, TGT, FL_OK);
            send_flit(1'b0, ID);
            send_flit(1'b0, TGT);
            send_flit(1'b0, FL_OK);
            send_flit(1'b1, FL_OK);
          end
          if (resp_plan == PL_OK || resp_plan == PL_FOREIGN) send_pkt(ID, TGT, FL_OK);
          else if (resp_plan == PL_ERR) send_pkt(ID, TGT, FL_ERR);
        end
      end
    end
  end

  // Monitor: pops the scoreboard on each accepted flit and checks stall stability.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) begin
        check("stall_valid", 32'(dout.valid), 32'd1);
        check("stall_flit", 32'({dout.last, dout.data}), 32'(prev_flit));
      end
      if (dout.valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (dout.valid && dready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_flit: got %h expected none", {dout.last, dout.data});
        end else begin
          check("flit", 32'({dout.last, dout.data}), 32'(exp_q.pop_front()));
        end
        if (mon_pos == 0 && last_f4_cyc >= 0) gaps.push_back(cyc - last_f4_cyc);
        if (dout.last) begin
          resp_pending++;
          last_f4_cyc = cyc;
          mon_pos = 0;
        end else begin
          mon_pos++;
        end
      end
      prev_stall = dout.valid && !dready;
      prev_flit  = {dout.last, dout.data};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic run_seq(input string tag, input logic which, input logic [15:0] base, input int count,
                         input logic exp_err, input int exp_cnt, input bit extra_start);
    int i;
    sel = which;
    cfg_base_r = base;
    cfg_cnt_r = 4'(count);
    first_valid_cyc = -1;
    last_f4_cyc = -1;
    gaps.delete();
    @(negedge clk);
    start_cyc = cyc;
    if (which) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    for (i = 0; i < 400; i++) begin
      if (done_s) break;
      if (extra_start && i == 5) begin
        start_a = 1'b1;
        cfg_base_r = 16'h0300;
        cfg_cnt_r = 4'd1;
      end
      if (i == 6) start_a = 1'b0;
      @(negedge clk);
    end
    start_a = 1'b0;
    check({tag, "_done_seen"}, 32'(i < 400), 32'd1);
    if (count == 0) check({tag, "_done_latency"}, 32'(i), 32'd0);
    else check({tag, "_first_flit_latency"}, 32'(first_valid_cyc - start_cyc), 32'd3);
    check({tag, "_busy_at_done"}, 32'(busy_s), 32'd0);
    check({tag, "_err"}, 32'(err_s), 32'(exp_err));
    check({tag, "_err_count"}, 32'(errc_s), 32'(exp_cnt));
    check({tag, "_flits_left"}, 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done_s), 32'd0);
    check({tag, "_busy_after"}, 32'(busy_s), 32'd0);
    repeat (30) @(negedge clk);
    exp_q.delete();
    plan_q.delete();
  endtask

  initial begin
    int i;
    for (int k = 0; k < 8; k++) mem[k] = 16'h0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(dout.valid), 32'd0);
    check("rst_busy", 32'(busy_s), 32'd0);
    check("rst_done", 32'(done_s), 32'd0);
    check("rst_err", 32'(err_s), 32'd0);
    check("rst_err_count", 32'(errc_s), 32'd0);
    check("rst_rd_en", 32'(rd_en_s), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("din_ready", 32'(dinr_s), 32'd1);

    // 1: three words, all succeed
    mem[0] = 16'hA0A0; mem[1] = 16'hB1B1; mem[2] = 16'hC2C2;
    for (int k = 0; k < 3; k++) begin expect_word(16'h0200, k, mem[k]); plan_q.push_back(PL_OK); end
    run_seq("t1", 1'b0, 16'h0200, 3, 1'b0, 0, 1'b0);

    // 2: random ring back-pressure, address wraps past 16'hFFFF
    ready_mode = 1;
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
    for (int k = 0; k < 4; k++) begin expect_word(16'hFFFE, k, mem[k]); plan_q.push_back(PL_OK); end
    run_seq("t2", 1'b0, 16'hFFFE, 4, 1'b0, 0, 1'b0);
    ready_mode = 0;

    // 3: error on word 1 aborts the sequence
    mem[0] = 16'h5A5A; mem[1] = 16'h6B6B; mem[2] = 16'h7C7C;
    expect_word(16'h0200, 0, mem[0]); expect_word(16'h0200, 1, mem[1]);
    plan_q.push_back(PL_OK); plan_q.push_back(PL_ERR);
    run_seq("t3", 1'b0, 16'h0200, 3, 1'b1, 1, 1'b0);

    // 4: no reply to word 0, timeout, sequence continues
    mem[0] = 16'h0D0D; mem[1] = 16'h0E0E; mem[2] = 16'h0F0F;
    for (int k = 0; k < 3; k++) expect_word(16'h0210, k, mem[k]);
    plan_q.push_back(PL_NONE); plan_q.push_back(PL_OK); plan_q.push_back(PL_OK);
    run_seq("t4", 1'b1, 16'h0210, 3, 1'b1, 1, 1'b0);
    check("t4_gap_count", 32'(gaps.size()), 32'd2);
    if (gaps.size() > 0) check("t4_timeout_gap", 32'(gaps[0]), 32'd20);

    // 5: foreign packets before the real reply; a start while busy is ignored
    mem[0] = 16'hCAFE; mem[1] = 16'hBEEF;
    expect_word(16'h0200, 0, mem[0]); expect_word(16'h0200, 1, mem[1]);
    plan_q.push_back(PL_FOREIGN); plan_q.push_back(PL_OK);
    run_seq("t5", 1'b0, 16'h0200, 2, 1'b0, 0, 1'b1);

    // 6a: empty sequence
    run_seq("t6", 1'b0, 16'h0200, 0, 1'b0, 0, 1'b0);

    // 6b: reset while a flit is stalled on the ring
    ready_mode = 2;
    sel = 1'b0;
    cfg_base_r = 16'h0220;
    cfg_cnt_r = 4'd2;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (i = 0; i < 10; i++) begin
      if (dout.valid) break;
      @(negedge clk);
    end
    check("t6_valid_before_rst", 32'(dout.valid), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(dout.valid), 32'd0);
    check("t6_rst_busy", 32'(busy_s), 32'd0);
    check("t6_rst_done", 32'(done_s), 32'd0);
    ready_mode = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("t6_no_resume", 32'(dout.valid), 32'd0);
    check("t6_no_done", 32'(done_s), 32'd0);

    // recovery after reset
    mem[0] = 16'h9876;
    expect_word(16'h0230, 0, mem[0]);
    plan_q.push_back(PL_OK);
    run_seq("t7", 1'b0, 16'h0230, 1, 1'b0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
